// File: rtl/cmp_sort_pipe.sv
// Pipelined odd-even transposition sorter: DATA_CNT registered compare-exchange stages
// carry key, original-position tag, direction and valid; the whole pipe stalls on output back-pressure.
module cmp_sort_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_CNT   = 8,
  parameter int SIGNED     = 0,
  localparam int IDX_W     = (DATA_CNT > 2) ? $clog2(DATA_CNT) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_dir,
  input  logic [DATA_CNT*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_dir,
  output logic [DATA_CNT*DATA_WIDTH-1:0] out_data,
  output logic [DATA_CNT*IDX_W-1:0]      out_idx
);

  logic stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  function automatic logic key_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic gt;
    if (SIGNED != 0) begin
      gt = ($signed(a) > $signed(b));
    end else begin
      gt = (a > b);
    end
    return gt;
  endfunction

  for (genvar s = 0; s < DATA_CNT; s++) begin : g_stage
    logic [DATA_WIDTH-1:0] src_key [DATA_CNT];
    logic [IDX_W-1:0]      src_tag [DATA_CNT];
    logic                  src_dir;
    logic                  src_vld;
    logic [DATA_WIDTH-1:0] key_d [DATA_CNT];
    logic [IDX_W-1:0]      tag_d [DATA_CNT];
    logic [DATA_WIDTH-1:0] key_q [DATA_CNT];
    logic [IDX_W-1:0]      tag_q [DATA_CNT];
    logic                  dir_q;
    logic                  vld_q;

    if (s == 0) begin : g_head
      // Stage 0 tags every element with its input position.
      always_comb begin
        for (int e = 0; e < DATA_CNT; e++) begin
          src_key[e] = in_data[e*DATA_WIDTH +: DATA_WIDTH];
          src_tag[e] = IDX_W'(e);
        end
      end
      assign src_dir = in_dir;
      assign src_vld = in_valid;
    end else begin : g_body
      always_comb begin
        for (int e = 0; e < DATA_CNT; e++) begin
          src_key[e] = g_stage[s-1].key_q[e];
          src_tag[e] = g_stage[s-1].tag_q[e];
        end
      end
      assign src_dir = g_stage[s-1].dir_q;
      assign src_vld = g_stage[s-1].vld_q;
    end

    // Even stages pair from element 0, odd stages from 1; strict compare keeps equal keys in order.
    always_comb begin
      logic swap;
      swap  = 1'b0;
      key_d = src_key;
      tag_d = src_tag;
      for (int e = s % 2; e + 1 < DATA_CNT; e += 2) begin
        swap       = src_dir ? key_gt(src_key[e+1], src_key[e]) : key_gt(src_key[e], src_key[e+1]);
        key_d[e]   = swap ? src_key[e+1] : src_key[e];
        key_d[e+1] = swap ? src_key[e]   : src_key[e+1];
        tag_d[e]   = swap ? src_tag[e+1] : src_tag[e];
        tag_d[e+1] = swap ? src_tag[e]   : src_tag[e+1];
      end
    end

    // Stage register: flush drops valid even while stalled; stall freezes everything.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        dir_q <= 1'b0;
        for (int e = 0; e < DATA_CNT; e++) begin
          key_q[e] <= '0;
          tag_q[e] <= '0;
        end
      end else begin
        if (flush) begin
          vld_q <= 1'b0;
        end else if (!stall) begin
          vld_q <= src_vld;
        end else begin
          vld_q <= vld_q;
        end
        if (!stall) begin
          dir_q <= src_dir;
          key_q <= key_d;
          tag_q <= tag_d;
        end else begin
          dir_q <= dir_q;
        end
      end
    end
  end

  // Outputs come straight from the last stage register.
  always_comb begin
    out_data = '0;
    out_idx  = '0;
    for (int e = 0; e < DATA_CNT; e++) begin
      out_data[e*DATA_WIDTH +: DATA_WIDTH] = g_stage[DATA_CNT-1].key_q[e];
      out_idx[e*IDX_W +: IDX_W]            = g_stage[DATA_CNT-1].tag_q[e];
    end
  end

  assign out_valid = g_stage[DATA_CNT-1].vld_q;
  assign out_dir   = g_stage[DATA_CNT-1].dir_q;

endmodule

// File: tb/tb_cmp_sort_pipe.sv
// Directed and randomized bench for cmp_sort_pipe: 4-element unsigned/signed instances
// share stimulus; 2- and 16-element instances are exercised by the random scoreboard run.
module tb_cmp_sort_pipe;

  logic         clk = 1'b0;
  logic         rst, flush, t_valid, t_dir, t_ordy;
  logic [127:0] t_data;
  int           sel;
  int           checks = 0;
  int           failures = 0;

  logic         r4, v4, dr4, rs, vs, drs, r2, v2, dr2, r16, v16, dr16;
  logic [31:0]  d4, ds;
  logic [7:0]   i4, is4;
  logic [15:0]  d2;
  logic [1:0]   i2;
  logic [127:0] d16;
  logic [63:0]  i16;
  logic         iv4, iv2, iv16, or4, or2, or16;

  logic         o_valid, o_ready, o_dir;
  logic [127:0] o_data;
  logic [63:0]  o_idx;

  logic [127:0] q_d[$];
  logic [63:0]  q_i[$];
  logic         q_r[$];

  always #5 clk = ~clk;

  assign iv4  = t_valid & (sel == 4);
  assign iv2  = t_valid & (sel == 2);
  assign iv16 = t_valid & (sel == 16);
  assign or4  = (sel == 4)  ? t_ordy : 1'b1;
  assign or2  = (sel == 2)  ? t_ordy : 1'b1;
  assign or16 = (sel == 16) ? t_ordy : 1'b1;

  cmp_sort_pipe #(.DATA_WIDTH(8), .DATA_CNT(4), .SIGNED(0)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv4), .in_ready(r4), .in_dir(t_dir),
    .in_data(t_data[31:0]), .out_valid(v4), .out_ready(or4), .out_dir(dr4), .out_data(d4), .out_idx(i4));
  cmp_sort_pipe #(.DATA_WIDTH(8), .DATA_CNT(4), .SIGNED(1)) u_dut4s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv4), .in_ready(rs), .in_dir(t_dir),
    .in_data(t_data[31:0]), .out_valid(vs), .out_ready(or4), .out_dir(drs), .out_data(ds), .out_idx(is4));
  cmp_sort_pipe #(.DATA_WIDTH(8), .DATA_CNT(2), .SIGNED(0)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv2), .in_ready(r2), .in_dir(t_dir),
    .in_data(t_data[15:0]), .out_valid(v2), .out_ready(or2), .out_dir(dr2), .out_data(d2), .out_idx(i2));
  cmp_sort_pipe #(.DATA_WIDTH(8), .DATA_CNT(16), .SIGNED(0)) u_dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv16), .in_ready(r16), .in_dir(t_dir),
    .in_data(t_data), .out_valid(v16), .out_ready(or16), .out_dir(dr16), .out_data(d16), .out_idx(i16));

  // Route the selected unsigned instance onto common observation signals.
  always_comb begin
    o_valid = v4;  o_ready = r4;  o_dir = dr4;  o_data = {96'd0, d4};  o_idx = {56'd0, i4};
    case (sel)
      2:  begin o_valid = v2;  o_ready = r2;  o_dir = dr2;  o_data = {112'd0, d2}; o_idx = {62'd0, i2}; end
      16: begin o_valid = v16; o_ready = r16; o_dir = dr16; o_data = d16;          o_idx = i16;          end
      default: begin o_valid = v4; o_ready = r4; o_dir = dr4; o_data = {96'd0, d4}; o_idx = {56'd0, i4}; end
    endcase
  end

  // Reference: stable insertion sort of the first n byte keys.
  function automatic void model(input logic [127:0] d, input logic dir, input int n,
                                output logic [127:0] ed, output logic [63:0] ei);
    logic [7:0] k [16];
    int         t [16];
    int         w, j, tt;
    logic [7:0] kk;
    w = (n == 2) ? 1 : ((n == 4) ? 2 : 4);
    for (int i = 0; i < n; i++) begin
      k[i] = d[i*8 +: 8];
      t[i] = i;
    end
    for (int i = 1; i < n; i++) begin
      kk = k[i]; tt = t[i]; j = i;
      while (j > 0 && (dir ? (k[j-1] < kk) : (k[j-1] > kk))) begin
        k[j] = k[j-1]; t[j] = t[j-1]; j--;
      end
      k[j] = kk; t[j] = tt;
    end
    ed = '0; ei = '0;
    for (int i = 0; i < n; i++) begin
      ed[i*8 +: 8] = k[i];
      for (int b = 0; b < w; b++) ei[i*w + b] = t[i][b];
    end
  endfunction

  task test_reset;
    rst = 1'b1; flush = 1'b0; t_valid = 1'b0; t_dir = 1'b0; t_ordy = 1'b1; t_data = '0; sel = 4;
    #2;
    checks++; if (v4 !== 1'b0) begin failures++; $display("FAIL reset_valid_during got=%0b exp=0", v4); end
    checks++; if (r4 !== 1'b1) begin failures++; $display("FAIL reset_ready_during got=%0b exp=1", r4); end
    repeat (3) @(negedge clk);
    checks++; if (d4 !== 32'h0 || i4 !== 8'h0 || dr4 !== 1'b0)
      begin failures++; $display("FAIL reset_data got=%0h/%0h/%0b exp=0/0/0", d4, i4, dr4); end
    checks++; if (v2 !== 1'b0 || v16 !== 1'b0 || vs !== 1'b0)
      begin failures++; $display("FAIL reset_valid_all got=%0b%0b%0b exp=000", v2, v16, vs); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (v4 !== 1'b0 || r4 !== 1'b1)
      begin failures++; $display("FAIL reset_release got=v%0b r%0b exp=v0 r1", v4, r4); end
  endtask

  task test_ascending;
    @(negedge clk);
    t_valid = 1'b1; t_dir = 1'b0; t_ordy = 1'b1; t_data = {96'd0, 32'h00020103};
    @(negedge clk);
    t_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      checks++; if (v4 !== 1'b0) begin failures++; $display("FAIL asc_latency_early cyc=%0d got=%0b exp=0", k, v4); end
      @(negedge clk);
    end
    checks++; if (v4 !== 1'b1) begin failures++; $display("FAIL asc_valid got=%0b exp=1", v4); end
    checks++; if (d4 !== 32'h03020100) begin failures++; $display("FAIL asc_data got=%0h exp=03020100", d4); end
    checks++; if (i4 !== 8'h27) begin failures++; $display("FAIL asc_idx got=%0h exp=27", i4); end
    checks++; if (dr4 !== 1'b0) begin failures++; $display("FAIL asc_dir got=%0b exp=0", dr4); end
    @(negedge clk);
  endtask

  task test_signed;
    @(negedge clk);
    t_valid = 1'b1; t_dir = 1'b0; t_ordy = 1'b1; t_data = {96'd0, 32'hFF007F80};
    @(negedge clk);
    t_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (vs !== 1'b1 || ds !== 32'h7F00FF80 || is4 !== 8'h6C)
      begin failures++; $display("FAIL signed_sort got=v%0b %0h/%0h exp=v1 7f00ff80/6c", vs, ds, is4); end
    checks++; if (v4 !== 1'b1 || d4 !== 32'hFF807F00 || i4 !== 8'hC6)
      begin failures++; $display("FAIL unsigned_sort got=v%0b %0h/%0h exp=v1 ff807f00/c6", v4, d4, i4); end
    @(negedge clk);
  endtask

  task test_stability;
    logic [31:0] sin [3];
    logic [31:0] sout [3];
    logic [7:0]  sidx [3];
    logic        sdir [3];
    sin  = '{32'h05050505, 32'h05050505, 32'h02040401};
    sout = '{32'h05050505, 32'h05050505, 32'h01020404};
    sidx = '{8'hE4, 8'hE4, 8'h39};
    sdir = '{1'b0, 1'b1, 1'b1};
    t_ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      t_valid = 1'b1; t_dir = sdir[i]; t_data = {96'd0, sin[i]};
    end
    @(negedge clk);
    t_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (v4 !== 1'b1 || d4 !== sout[i] || i4 !== sidx[i] || dr4 !== sdir[i])
        begin failures++; $display("FAIL stable_%0d got=v%0b %0h/%0h/%0b exp=v1 %0h/%0h/%0b",
                                   i, v4, d4, i4, dr4, sout[i], sidx[i], sdir[i]); end
    end
    @(negedge clk);
  endtask

  task test_back_to_back;
    logic [31:0] bin [6];
    logic [31:0] bout [6];
    logic [7:0]  bidx [6];
    logic        bdir [6];
    logic        exp_rdy;
    int          sent, recv;
    bin  = '{32'h01020304, 32'h08090809, 32'h04030201, 32'h04030201, 32'h101000FF, 32'h07030707};
    bout = '{32'h04030201, 32'h08080909, 32'h04030201, 32'h01020304, 32'hFF101000, 32'h03070707};
    bidx = '{8'h1B, 8'hD8, 8'hE4, 8'h1B, 8'h39, 8'hB4};
    bdir = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      t_ordy = !(cyc >= 5 && cyc <= 7);
      if (sent < 6) begin
        t_valid = 1'b1; t_data = {96'd0, bin[sent]}; t_dir = bdir[sent];
      end else begin
        t_valid = 1'b0; t_data = '0; t_dir = 1'b0;
      end
      #1;
      if (cyc < 12) begin
        exp_rdy = !(cyc >= 5 && cyc <= 7);
        checks++; if (o_ready !== exp_rdy)
          begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=%0b", cyc, o_ready, exp_rdy); end
      end
      if (t_valid && o_ready) sent++;
      if (o_valid && t_ordy) begin
        if (recv >= 6) begin
          checks++; failures++; $display("FAIL bp_extra_output cyc=%0d got=%0h exp=none", cyc, o_data);
        end else begin
          checks++; if (o_data[31:0] !== bout[recv] || o_idx[7:0] !== bidx[recv] || o_dir !== bdir[recv])
            begin failures++; $display("FAIL bp_vec_%0d got=%0h/%0h/%0b exp=%0h/%0h/%0b", recv,
                                       o_data[31:0], o_idx[7:0], o_dir, bout[recv], bidx[recv], bdir[recv]); end
          recv++;
        end
      end
    end
    t_valid = 1'b0; t_ordy = 1'b1;
    checks++; if (sent != 6 || recv != 6)
      begin failures++; $display("FAIL bp_counts got=sent%0d recv%0d exp=sent6 recv6", sent, recv); end
  endtask

  task test_flush;
    t_ordy = 1'b1; t_dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (v4 !== 1'b0) begin failures++; $display("FAIL flush_pre_valid i=%0d got=%0b exp=0", i, v4); end
      t_valid = 1'b1; t_data = {96'd0, 32'h00020103};
      flush = (i == 3);
    end
    @(negedge clk);
    flush = 1'b0; t_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (v4 !== 1'b0 || r4 !== 1'b1)
        begin failures++; $display("FAIL flush_drop i=%0d got=v%0b r%0b exp=v0 r1", i, v4, r4); end
      @(negedge clk);
    end
    t_valid = 1'b1; t_data = {96'd0, 32'h00020103};
    @(negedge clk);
    t_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (v4 !== 1'b1 || d4 !== 32'h03020100 || i4 !== 8'h27)
      begin failures++; $display("FAIL flush_recover got=v%0b %0h/%0h exp=v1 03020100/27", v4, d4, i4); end
    @(negedge clk);
  endtask

  task test_reset_midstream;
    t_ordy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      t_valid = 1'b1; t_dir = 1'b1; t_data = {96'd0, 32'h01020304};
    end
    t_valid = 1'b0;
    #1;
    checks++; if (v4 !== 1'b1 || d4 !== 32'h01020304 || dr4 !== 1'b1)
      begin failures++; $display("FAIL rst_pre_stream got=v%0b %0h/%0b exp=v1 01020304/1", v4, d4, dr4); end
    rst = 1'b1;
    #1;
    checks++; if (v4 !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0b exp=0", v4); end
    checks++; if (r4 !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%0b exp=1", r4); end
    checks++; if (d4 !== 32'h0 || i4 !== 8'h0 || dr4 !== 1'b0)
      begin failures++; $display("FAIL rst_mid_data got=%0h/%0h/%0b exp=0/0/0", d4, i4, dr4); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (v4 !== 1'b0 || r4 !== 1'b1)
        begin failures++; $display("FAIL rst_no_reappear i=%0d got=v%0b r%0b exp=v0 r1", i, v4, r4); end
    end
  endtask

  task test_random(input int n, input int nvec);
    logic [127:0] ed;
    logic [63:0]  ei;
    int           acc, guard;
    @(negedge clk);
    sel = n; acc = 0; guard = 0;
    while ((acc < nvec || q_d.size() != 0) && guard < nvec * 8 + 200) begin
      @(negedge clk);
      t_valid = (acc < nvec) && ($urandom % 4 != 0);
      t_dir   = 1'($urandom % 2);
      t_ordy  = (acc >= nvec) || ($urandom % 4 != 0);
      for (int e = 0; e < 16; e++)
        t_data[e*8 +: 8] = ($urandom % 2 == 0) ? 8'($urandom % 4) : 8'($urandom);
      #1;
      if (t_valid && o_ready) begin
        model(t_data, t_dir, n, ed, ei);
        q_d.push_back(ed); q_i.push_back(ei); q_r.push_back(t_dir);
        acc++;
      end
      if (o_valid && t_ordy) begin
        if (q_d.size() == 0) begin
          checks++; failures++; $display("FAIL rand%0d_unexpected got=%0h exp=none", n, o_data);
        end else begin
          ed = q_d.pop_front(); ei = q_i.pop_front();
          checks++; if (o_data !== ed) begin failures++; $display("FAIL rand%0d_data got=%0h exp=%0h", n, o_data, ed); end
          checks++; if (o_idx !== ei) begin failures++; $display("FAIL rand%0d_idx got=%0h exp=%0h", n, o_idx, ei); end
          checks++; if (o_dir !== q_r[0]) begin failures++; $display("FAIL rand%0d_dir got=%0b exp=%0b", n, o_dir, q_r[0]); end
          void'(q_r.pop_front());
        end
      end
      guard++;
    end
    t_valid = 1'b0; t_ordy = 1'b1;
    checks++; if (acc != nvec || q_d.size() != 0)
      begin failures++; $display("FAIL rand%0d_timeout got=acc%0d pend%0d exp=acc%0d pend0", n, acc, q_d.size(), nvec); end
    q_d.delete(); q_i.delete(); q_r.delete();
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_signed();
    test_stability();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random(4, 4000);
    test_random(2, 3000);
    test_random(16, 3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
